// File: rtl/fwd_hazard_unit.sv
// Decode-stage operand forwarding and hazard detection.
// Tracks in-flight writers and picks the youngest ready source.
module fwd_hazard_unit #(
  parameter int NRP   = 2,
  parameter int DEPTH = 3,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int SW    = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_wa,
  input  logic [1:0]        id_tnew,
  input  logic [NRP*AW-1:0] id_ra,
  input  logic [NRP*2-1:0]  id_tuse,
  input  logic [NRP*DW-1:0] id_rd,
  input  logic [DEPTH*DW-1:0] stage_wd,
  input  logic              ext_stall,
  input  logic              flush,
  output logic              stall,
  output logic [NRP*DW-1:0] op_d,
  output logic [NRP*SW-1:0] fwd_sel
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [AW-1:0]    wa_q   [DEPTH];
  logic [AW-1:0]    wa_d   [DEPTH];
  logic [1:0]       tnew_q [DEPTH];
  logic [1:0]       tnew_d [DEPTH];
  logic [NRP-1:0]   hz;

  // Per-port youngest-match search; smaller k overrides older hits.
  always_comb begin
    logic [AW-1:0] ra;
    logic [1:0]    tuse;
    op_d    = id_rd;
    fwd_sel = '0;
    hz      = '0;
    for (int p = 0; p < NRP; p++) begin
      ra   = id_ra[p*AW +: AW];
      tuse = id_tuse[p*2 +: 2];
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (v_q[k] && wa_q[k] == ra && ra != '0) begin
          hz[p] = tnew_q[k] > tuse;
          if (tnew_q[k] == 2'd0) begin
            op_d[p*DW +: DW]    = stage_wd[k*DW +: DW];
            fwd_sel[p*SW +: SW] = SW'(k+1);
          end else begin
            op_d[p*DW +: DW]    = id_rd[p*DW +: DW];
            fwd_sel[p*SW +: SW] = '0;
          end
        end
      end
    end
    stall = ext_stall | (id_valid & (|hz));
  end

  // Tag pipeline next state: flush empties, otherwise shift and age.
  always_comb begin
    v_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      wa_d[k]   = '0;
      tnew_d[k] = '0;
    end
    if (!flush) begin
      if (id_valid && !stall) begin
        v_d[0]    = 1'b1;
        wa_d[0]   = id_wa;
        tnew_d[0] = id_tnew;
      end
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]    = v_q[k-1];
        wa_d[k]   = wa_q[k-1];
        tnew_d[k] = (tnew_q[k-1] == 2'd0) ? 2'd0 : tnew_q[k-1] - 2'd1;
      end
    end
  end

  // Tag state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        wa_q[k]   <= wa_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit.
// Hand-computed vectors for forwarding, stalls and control.
module tb_fwd_hazard_unit;
  localparam int NRP = 2;
  localparam int DEPTH = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              id_valid;
  logic [AW-1:0]     id_wa;
  logic [1:0]        id_tnew;
  logic [NRP*AW-1:0] id_ra;
  logic [NRP*2-1:0]  id_tuse;
  logic [NRP*DW-1:0] id_rd;
  logic [DEPTH*DW-1:0] stage_wd;
  logic              ext_stall;
  logic              flush;
  logic              stall;
  logic [NRP*DW-1:0] op_d;
  logic [NRP*SW-1:0] fwd_sel;

  fwd_hazard_unit #(
    .NRP(NRP), .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_wa(id_wa), .id_tnew(id_tnew), .id_ra(id_ra),
    .id_tuse(id_tuse), .id_rd(id_rd), .stage_wd(stage_wd),
    .ext_stall(ext_stall), .flush(flush), .stall(stall),
    .op_d(op_d), .fwd_sel(fwd_sel)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input int p, input logic [AW-1:0] ra,
                      input logic [1:0] tu, input logic [DW-1:0] rd);
    id_ra[p*AW +: AW]   = ra;
    id_tuse[p*2 +: 2]   = tu;
    id_rd[p*DW +: DW]   = rd;
  endtask

  task automatic issue(input logic v, input logic [AW-1:0] wa,
                       input logic [1:0] tn);
    id_valid = v;
    id_wa    = wa;
    id_tnew  = tn;
  endtask

  initial begin
    reset = 1'b1;
    ext_stall = 1'b0;
    flush = 1'b0;
    issue(0, 0, 0);
    port(0, 0, 0, 32'hA0);
    port(1, 0, 0, 32'hB0);
    stage_wd = {32'h33, 32'h1234, 32'h5555};
    step();
    step();
    ext_stall = 1'b1;
    #1;
    chk("rst_ext", {31'd0, stall}, 32'd1);
    ext_stall = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    step();

    // empty tags
    port(0, 5, 0, 32'hA);
    port(1, 6, 0, 32'hB);
    #1;
    chk("empty_op0", op_d[31:0], 32'hA);
    chk("empty_op1", op_d[63:32], 32'hB);
    chk("empty_sel", {28'd0, fwd_sel}, 32'd0);
    chk("empty_stall", {31'd0, stall}, 32'd0);

    // ALU forward
    issue(1, 5, 1);
    step();
    issue(1, 0, 0);
    port(0, 5, 0, 32'hA);
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("alu_op0", op_d[31:0], 32'h1234);
    chk("alu_sel", {28'd0, fwd_sel}, 32'h2);
    chk("alu_nostall", {31'd0, stall}, 32'd0);

    // load-use
    port(0, 0, 0, 32'hA);
    port(1, 0, 0, 32'hB);
    issue(1, 7, 2);
    step();
    issue(1, 0, 0);
    port(0, 7, 1, 32'hA);
    #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_nostall", {31'd0, stall}, 32'd0);
    chk("lu_sel", {28'd0, fwd_sel}, 32'd0);
    chk("lu_op0", op_d[31:0], 32'hA);

    // youngest wins
    port(0, 0, 0, 32'hA);
    issue(1, 3, 0);
    step();
    step();
    issue(0, 0, 0);
    stage_wd = {32'h33, 32'h22, 32'h11};
    port(0, 3, 0, 32'hA);
    port(1, 3, 2, 32'hB);
    #1;
    chk("yw_op0", op_d[31:0], 32'h11);
    chk("yw_op1", op_d[63:32], 32'h11);
    chk("yw_sel", {28'd0, fwd_sel}, 32'h5);
    chk("yw_stall", {31'd0, stall}, 32'd0);

    // max stall tnew=2 tuse=0
    port(0, 0, 0, 32'hA);
    port(1, 0, 0, 32'hB);
    issue(1, 9, 2);
    step();
    issue(1, 0, 0);
    port(0, 9, 0, 32'hA);
    #1;
    chk("ms_stall1", {31'd0, stall}, 32'd1);
    step();
    chk("ms_stall2", {31'd0, stall}, 32'd1);
    step();
    chk("ms_done", {31'd0, stall}, 32'd0);
    chk("ms_sel", {28'd0, fwd_sel}, 32'h3);
    chk("ms_op0", op_d[31:0], 32'h33);

    // tnew equals tuse: no stall, no forward
    port(0, 0, 0, 32'hA);
    issue(1, 10, 1);
    step();
    issue(1, 0, 0);
    port(0, 10, 1, 32'hA);
    #1;
    chk("eq_stall", {31'd0, stall}, 32'd0);
    chk("eq_sel", {28'd0, fwd_sel}, 32'd0);

    // hazard gated by id_valid
    port(0, 0, 0, 32'hA);
    issue(1, 17, 2);
    step();
    issue(0, 0, 0);
    port(0, 17, 0, 32'hA);
    #1;
    chk("gate_stall", {31'd0, stall}, 32'd0);

    // register zero
    port(0, 0, 0, 32'hA);
    issue(1, 0, 2);
    step();
    issue(1, 0, 0);
    port(0, 0, 0, 32'hC);
    #1;
    chk("r0_stall", {31'd0, stall}, 32'd0);
    chk("r0_sel", {28'd0, fwd_sel}, 32'd0);
    chk("r0_op0", op_d[31:0], 32'hC);

    // external stall inserts a bubble
    port(0, 0, 0, 32'hA);
    issue(1, 13, 0);
    ext_stall = 1'b1;
    #1;
    chk("ext_stall", {31'd0, stall}, 32'd1);
    step();
    ext_stall = 1'b0;
    issue(0, 0, 0);
    port(0, 13, 0, 32'hA);
    #1;
    chk("ext_bubble", {28'd0, fwd_sel}, 32'd0);
    chk("ext_clear", {31'd0, stall}, 32'd0);

    // flush during load-use stall
    port(0, 0, 0, 32'hA);
    issue(1, 14, 2);
    step();
    issue(1, 0, 0);
    port(0, 14, 0, 32'hA);
    #1;
    chk("fl_pre", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);

    // flush also drops the D load
    port(0, 0, 0, 32'hA);
    issue(1, 15, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue(0, 0, 0);
    port(0, 15, 0, 32'hA);
    #1;
    chk("fl_load", {28'd0, fwd_sel}, 32'd0);

    // reset mid-stall
    port(0, 0, 0, 32'hA);
    issue(1, 16, 2);
    step();
    issue(1, 0, 0);
    port(0, 16, 0, 32'hA);
    #1;
    chk("rs_pre", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rs_stall", {31'd0, stall}, 32'd0);
    chk("rs_sel", {28'd0, fwd_sel}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and hazard unit for the decode stage of the pipelined MIPS core. It replaces the fixed two-port, fixed-source decode forwarding mux. It keeps its own tag pipeline of in-flight writers (destination register, Tnew) alongside the datapath stages. For each of NRP decode read ports it selects the youngest ready forwarding source, and it raises `stall` when a required operand cannot be ready by its Tuse.

## Interface
Parameters:
- `NRP`, 2, number of decode read ports.
- `DEPTH`, 3, number of tracked writer stages after D (index 0 = E, 1 = M, 2 = W).
- `AW`, 5, register address width.
- `DW`, 32, data width.
- `SW`, `$clog2(DEPTH+1)`, forwarding-select width (derived; not overridden).

Ports:
- `clk`  in  1  Clock. One clock domain.
- `reset`  in  1  Synchronous, active-high reset.
- `id_valid`  in  1  D holds a real instruction.
- `id_wa`  in  AW  Destination register of the D instruction. 0 means no write.
- `id_tnew`  in  2  Cycles after entering E until the D instruction's result exists.
- `id_ra`  in  NRP*AW  Source register per port. Port p occupies bits `[p*AW +: AW]`.
- `id_tuse`  in  NRP*2  Cycles until port p's operand is consumed. 0 = consumed in D.
- `id_rd`  in  NRP*DW  Register-file read data per port.
- `stage_wd`  in  DEPTH*DW  Result currently held by stage k, at `[k*DW +: DW]`.
- `ext_stall`  in  1  External stall request, e.g. HI/LO unit busy.
- `flush`  in  1  Synchronous clear of all tracked stages.
- `stall`  out  1  Freezes PC and the F/D register. A bubble enters E.
- `op_d`  out  NRP*DW  Forwarded operand per port.
- `fwd_sel`  out  NRP*SW  Per port: 0 = register file, k+1 = stage k.

## Operation
- Tag pipeline: DEPTH entries, each holding {`v`, `wa[AW-1:0]`, `tnew[1:0]`}.
- Each cycle, entry k moves to k+1 with tnew decremented, saturating at 0. Entry DEPTH-1 retires.
- Entry 0 loads {1, `id_wa`, `id_tnew`} when `id_valid && !stall`. Otherwise it loads a bubble {0, 0, 0}.
- Match rule for port p at stage k: `v[k] && wa[k]==ra_p && ra_p!=0`. Register 0 never matches.
- Winner for port p is the matching entry with the smallest k (the youngest writer).
- No winner: `op_d = id_rd`, `fwd_sel = 0`, no hazard.
- Winner with `tnew[k] > tuse_p`: hazard. `fwd_sel = 0` and `op_d = id_rd` (value ignored).
- Winner with `tnew[k] == 0`: `op_d = stage_wd[k]`, `fwd_sel = k+1`.
- Winner with `0 < tnew[k] <= tuse_p`: `op_d = id_rd`, `fwd_sel = 0`. Later-stage muxes resolve the operand. An older ready match is NOT used.
- `stall = ext_stall | OR(hazard_p)` across all ports, gated by `id_valid`. Exception: `ext_stall` alone always asserts `stall`.
- Priority of next-state updates: `reset` > `flush` > normal shift.
- `flush` clears `v`, `wa` and `tnew` in all entries, including the entry that would otherwise load from D.

## Timing
- `op_d`, `fwd_sel` and `stall` are combinational from the inputs and the current tag state. Zero-cycle latency.
- The tag state updates on the rising `clk` edge.
- Reset value of all entries: `v=0`, `wa=0`, `tnew=0`. In the reset cycle and the cycle after, `stall = ext_stall`, `op_d = id_rd`, `fwd_sel = 0`.
- An issued writer is visible to the D-stage match exactly one cycle after issue, as entry 0.
- Its tnew at stage k equals `max(id_tnew - k, 0)`.
- A hazard stall persists until the winning entry's tnew is at most tuse. Each stall cycle inserts exactly one bubble.
- With `DEPTH=3`, the maximum stall length is 2 cycles, for `tnew=2, tuse=0`.
- `ext_stall` and a hazard asserted together produce a single bubble per cycle and no double counting.
- `flush` asserted together with a hazard empties the tags, so `stall` drops in the next cycle unless `ext_stall` is high.

## Test plan
- **Empty tags:** after `reset`, drive `id_ra`={5,6} and `id_rd`={0xA,0xB}. Required: `op_d`={0xA,0xB}, `fwd_sel`={0,0}, `stall=0`.
- **ALU forward:** issue wa=5 tnew=1. Next cycle, a port with ra=5 and tuse=0 gives `stall=1`. The following cycle, the entry is at stage 1 with tnew 0 and `stage_wd[1]=0x1234`, giving `op_d=0x1234`, `fwd_sel=2`, `stall=0`.
- **Load-use:** issue wa=7 tnew=2. Next cycle, ra=7 tuse=1 gives `stall=1` for exactly one cycle. Entry 0 then holds a bubble. After that, tnew=1 at stage 1 gives `stall=0`, `fwd_sel=0`.
- **Youngest wins:** set stages 0 and 1 to wa=3 tnew=0 with `stage_wd`={0x11,0x22}. ra=3 gives `op_d=0x11`, `fwd_sel=1`.
- **Register zero:** issue wa=0 tnew=2, then ra=0 tuse=0. Required: `stall=0`, `fwd_sel=0`, `op_d=id_rd`.
- **Control:** `ext_stall=1` with `id_valid=1` gives `stall=1` and a bubble in entry 0. Asserting `flush` while a load-use stall is active gives all `v=0` next cycle and `stall=0`. Asserting `reset` mid-stall gives the same result.
